// File: rtl/op2_feed_pkg.sv
// Shared constants, FSM encoding and frame type for the op2_feed front end.
`default_nettype none

package op2_feed_pkg;

  localparam int DW    = 12;
  localparam int NW    = 16;
  localparam int CNT_W = 4;
  localparam int SUM_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    SUMV    = 2'd2
  } state_t;

  // Element K of a frame feeds adder input K.
  typedef logic [NW-1:0][DW-1:0] frame_t;

endpackage

`default_nettype wire

// File: rtl/op2_feed_if.sv
// Stream-in / frame-out bus between the upstream producer, op2_feed and the adder side.
`default_nettype none

interface op2_feed_if #(
  parameter int FCW = 16
);
  import op2_feed_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    data_in;
  frame_t           data_out;
  logic             sum_valid;
  logic             sum_ack;
  logic [FCW-1:0]   frame_cnt;

  modport master (
    output in_valid, data_in, sum_ack,
    input  in_ready, data_out, sum_valid, frame_cnt
  );

  modport slave (
    input  in_valid, data_in, sum_ack,
    output in_ready, data_out, sum_valid, frame_cnt
  );

endinterface

`default_nettype wire

// File: rtl/op2_feed_bank.sv
// 15-slot fill register file plus the 16-word output bank loaded on commit.
`default_nettype none

module op2_feed_bank
  import op2_feed_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             commit,
  input  logic [CNT_W-1:0] wr_idx,
  input  logic [DW-1:0]    data_in,
  output frame_t           data_out
);

  logic [DW-1:0] slot [NW-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NW-1; k++) slot[k] <= '0;
    end else if (wr_en) begin
      slot[wr_idx] <= data_in;
    end
  end

  // The last word bypasses the fill file and lands directly in the output bank.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
    end else if (commit) begin
      for (int k = 0; k < NW-1; k++) data_out[k] <= slot[k];
      data_out[NW-1] <= data_in;
    end
  end

endmodule

`default_nettype wire

// File: rtl/op2_feed.sv
// Gathers 16 streamed words into a frame, presents it to the 16-input adder and tracks the sum handshake.
`default_nettype none

module op2_feed
  import op2_feed_pkg::*;
#(
  parameter int FCW = 16
) (
  input  logic      clock,
  input  logic      reset,
  op2_feed_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NW-1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [FCW-1:0]   frame_cnt;
  logic             last_slot;
  logic             commit_ok;
  logic             accept;
  logic             commit;

  assign last_slot = (cnt == LAST_IDX);
  assign commit_ok = (state == IDLE) || ((state == SUMV) && bus.sum_ack);

  // Only the 16th word can stall: the output bank must be free before it is overwritten.
  assign bus.in_ready = !last_slot || commit_ok;
  assign accept       = bus.in_valid && bus.in_ready;
  assign commit       = accept && last_slot;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (commit) state_nxt = PRESENT;
      PRESENT: state_nxt = SUMV;
      SUMV:    if (bus.sum_ack) state_nxt = commit ? PRESENT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      frame_cnt <= '0;
    end else begin
      if (accept) cnt <= commit ? '0 : cnt + 1'b1;
      if (commit) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign bus.sum_valid = (state == SUMV);
  assign bus.frame_cnt = frame_cnt;

  op2_feed_bank u_bank (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (accept && !last_slot),
    .commit   (commit),
    .wr_idx   (cnt),
    .data_in  (bus.data_in),
    .data_out (bus.data_out)
  );

endmodule

`default_nettype wire

// File: tb/tb_op2_feed.sv
// Scoreboard bench for op2_feed: expected frames queued on the 16th accept, compared when sum_valid rises.
`default_nettype none

module tb_op2_feed;
  import op2_feed_pkg::*;

  typedef struct packed {
    frame_t           w;
    logic [SUM_W-1:0] sum;
    logic [15:0]      fc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  op2_feed_if #(.FCW(16)) bus  ();
  op2_feed_if #(.FCW(2))  bus2 ();

  op2_feed #(.FCW(16)) dut  (.clock(clock), .reset(reset), .bus(bus.slave));
  op2_feed #(.FCW(2))  dut2 (.clock(clock), .reset(reset), .bus(bus2.slave));

  int          checks   = 0;
  int          failures = 0;
  exp_t        sb[$];
  frame_t      cur;
  int          widx     = 0;
  logic [15:0] exp_fc   = '0;

  function automatic logic [SUM_W-1:0] adder(input frame_t f);
    logic [SUM_W-1:0] s = '0;
    for (int k = 0; k < NW; k++) s = s + SUM_W'(f[k]);
    return s;
  endfunction

  // Offer one word; called near a negedge, returns at a later negedge.
  task automatic send(input logic [DW-1:0] d);
    bit   done = 0;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.data_in  = d;
    for (int i = 0; i < 64 && !done; i++) begin
      #1;
      if (bus.in_ready) begin
        done      = 1;
        cur[widx] = d;
        if (widx == NW-1) begin
          exp_fc = exp_fc + 16'd1;
          e.w    = cur;
          e.sum  = adder(cur);
          e.fc   = exp_fc;
          sb.push_back(e);
          widx = 0;
        end else begin
          widx++;
        end
      end
      @(negedge clock);
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout word %h got in_ready=0 for 64 cycles want accept", d);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.data_in = '0; bus.sum_ack = 0;
    bus2.in_valid = 0; bus2.data_in = '0; bus2.sum_ack = 0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (bus.data_out !== '0) begin failures++; $display("FAIL rst_data_out got %h want 0", bus.data_out); end
    checks++; if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL rst_sum_valid got %b want 0", bus.sum_valid); end
    checks++; if (bus.frame_cnt !== 16'd0) begin failures++; $display("FAIL rst_frame_cnt got %0d want 0", bus.frame_cnt); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
    @(negedge clock);
  endtask

  task automatic test_single_frame();
    frame_t           exp_f;
    exp_t             e;
    logic [SUM_W-1:0] s;
    for (int k = 0; k < NW; k++) exp_f[k] = DW'(k+1);
    bus.sum_ack = 1'b1;
    for (int k = 0; k < NW; k++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL t1_in_ready word %0d got %b want 1", k, bus.in_ready); end
      send(DW'(k+1));
    end
    #1;
    checks++; if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL t1_sv_present got %b want 0", bus.sum_valid); end
    checks++; if (bus.data_out !== exp_f) begin failures++; $display("FAIL t1_data_out got %h want %h", bus.data_out, exp_f); end
    @(negedge clock); #1;
    checks++; if (bus.sum_valid !== 1'b1) begin failures++; $display("FAIL t1_sv_rise got %b want 1", bus.sum_valid); end
    if (sb.size() == 0) begin
      checks++; failures++; $display("FAIL t1_sb_empty got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      s = adder(bus.data_out);
      checks++; if (bus.data_out !== e.w) begin failures++; $display("FAIL t1_frame got %h want %h", bus.data_out, e.w); end
      checks++; if (s !== e.sum) begin failures++; $display("FAIL t1_sum got %h want %h", s, e.sum); end
      checks++; if (s !== 16'd136) begin failures++; $display("FAIL t1_sum136 got %0d want 136", s); end
      checks++; if (bus.frame_cnt !== e.fc) begin failures++; $display("FAIL t1_frame_cnt got %0d want %0d", bus.frame_cnt, e.fc); end
    end
    @(negedge clock); #1;
    checks++; if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL t1_sv_pulse got %b want 0", bus.sum_valid); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    exp_t             e;
    logic [SUM_W-1:0] s;
    frame_t           all_fff;
    for (int k = 0; k < NW; k++) all_fff[k] = 12'hFFF;
    bus.sum_ack = 1'b0;
    for (int k = 0; k < NW; k++) send(12'h001);
    for (int k = 0; k < NW-1; k++) send(12'hFFF);
    fork
      send(12'hFFF);
      begin
        for (int c = 0; c < 3; c++) begin
          #2;
          checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL t2_stall cyc %0d got in_ready=%b want 0", c, bus.in_ready); end
          checks++; if (bus.data_out[0] !== 12'h001 || bus.sum_valid !== 1'b1) begin
            failures++; $display("FAIL t2_hold cyc %0d got d0=%h sv=%b want 001/1", c, bus.data_out[0], bus.sum_valid);
          end
          @(negedge clock);
        end
        bus.sum_ack = 1'b1;
        #2;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL t2_ack_ready got %b want 1", bus.in_ready); end
        if (sb.size() == 0) begin
          checks++; failures++; $display("FAIL t2_sb1_empty got 0 entries want 2");
        end else begin
          e = sb.pop_front();
          s = adder(bus.data_out);
          checks++; if (bus.data_out !== e.w) begin failures++; $display("FAIL t2_frame1 got %h want %h", bus.data_out, e.w); end
          checks++; if (s !== 16'h0010) begin failures++; $display("FAIL t2_sum1 got %h want 0010", s); end
        end
      end
    join
    #1;
    checks++; if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL t2_present got sv=%b want 0", bus.sum_valid); end
    checks++; if (bus.data_out !== all_fff) begin failures++; $display("FAIL t2_new_frame got %h want %h", bus.data_out, all_fff); end
    @(negedge clock); #1;
    checks++; if (bus.sum_valid !== 1'b1) begin failures++; $display("FAIL t2_sv2 got %b want 1", bus.sum_valid); end
    if (sb.size() == 0) begin
      checks++; failures++; $display("FAIL t2_sb2_empty got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      s = adder(bus.data_out);
      checks++; if (s !== e.sum || s !== 16'hFFF0) begin failures++; $display("FAIL t2_sum2 got %h want %h", s, e.sum); end
      checks++; if (bus.frame_cnt !== e.fc) begin failures++; $display("FAIL t2_frame_cnt got %0d want %0d", bus.frame_cnt, e.fc); end
    end
    @(negedge clock); #1;
    checks++; if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL t2_sv2_drop got %b want 0", bus.sum_valid); end
    @(negedge clock);
  endtask

  task automatic test_gappy();
    frame_t           exp_f;
    exp_t             e;
    logic [SUM_W-1:0] s;
    for (int k = 0; k < NW; k++) exp_f[k] = DW'(k+1);
    bus.sum_ack = 1'b1;
    for (int k = 0; k < NW; k++) begin
      send(DW'(k+1));
      if (k < NW-1) begin
        bus.data_in = 12'hBAD;
        @(negedge clock);
      end
    end
    #1;
    checks++; if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL t3_sv_present got %b want 0", bus.sum_valid); end
    @(negedge clock); #1;
    checks++; if (bus.sum_valid !== 1'b1) begin failures++; $display("FAIL t3_sv_rise got %b want 1", bus.sum_valid); end
    checks++; if (bus.data_out !== exp_f) begin failures++; $display("FAIL t3_frame_const got %h want %h", bus.data_out, exp_f); end
    if (sb.size() == 0) begin
      checks++; failures++; $display("FAIL t3_sb_empty got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      s = adder(bus.data_out);
      checks++; if (s !== e.sum) begin failures++; $display("FAIL t3_sum got %h want %h", s, e.sum); end
      checks++; if (bus.frame_cnt !== e.fc) begin failures++; $display("FAIL t3_frame_cnt got %0d want %0d", bus.frame_cnt, e.fc); end
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_frame();
    exp_t             e;
    logic [SUM_W-1:0] s;
    bus.sum_ack = 1'b0;
    for (int k = 0; k < NW; k++) send(12'h100 + DW'(k));
    for (int k = 0; k < 8; k++) send(12'h200 + DW'(k));
    #1;
    checks++; if (bus.sum_valid !== 1'b1) begin failures++; $display("FAIL t4_pending got sv=%b want 1", bus.sum_valid); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.data_out !== '0) begin failures++; $display("FAIL t4_async_data got %h want 0", bus.data_out); end
    checks++; if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL t4_async_sv got %b want 0", bus.sum_valid); end
    checks++; if (bus.frame_cnt !== 16'd0 || bus2.frame_cnt !== 2'd0) begin
      failures++; $display("FAIL t4_async_fc got %0d/%0d want 0/0", bus.frame_cnt, bus2.frame_cnt);
    end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL t4_async_ready got %b want 1", bus.in_ready); end
    sb.delete();
    widx   = 0;
    exp_fc = '0;
    @(negedge clock);
    reset = 1'b1;
    bus.sum_ack = 1'b1;
    for (int k = 0; k < NW; k++) send(DW'(k*37 + 5));
    @(negedge clock); #1;
    checks++; if (bus.sum_valid !== 1'b1) begin failures++; $display("FAIL t4_clean_sv got %b want 1", bus.sum_valid); end
    if (sb.size() != 1) begin
      checks++; failures++; $display("FAIL t4_sb_size got %0d entries want 1", sb.size());
    end else begin
      e = sb.pop_front();
      s = adder(bus.data_out);
      checks++; if (bus.data_out !== e.w) begin failures++; $display("FAIL t4_clean_frame got %h want %h", bus.data_out, e.w); end
      checks++; if (s !== e.sum) begin failures++; $display("FAIL t4_clean_sum got %h want %h", s, e.sum); end
      checks++; if (bus.frame_cnt !== 16'd1) begin failures++; $display("FAIL t4_clean_fc got %0d want 1", bus.frame_cnt); end
    end
    @(negedge clock);
  endtask

  task automatic test_ack_ignored();
    exp_t e;
    bus.sum_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.sum_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        failures++; $display("FAIL t5_idle_ack cyc %0d got sv=%b rdy=%b want 0/1", c, bus.sum_valid, bus.in_ready);
      end
      @(negedge clock);
    end
    for (int k = 0; k < NW; k++) send(12'h800 ^ DW'(k));
    #1;
    checks++; if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL t5_present got sv=%b want 0", bus.sum_valid); end
    bus.sum_ack = 1'b0;
    @(negedge clock); #1;
    checks++; if (bus.sum_valid !== 1'b1) begin failures++; $display("FAIL t5_not_skipped got sv=%b want 1", bus.sum_valid); end
    if (sb.size() == 0) begin
      checks++; failures++; $display("FAIL t5_sb_empty got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      checks++; if (adder(bus.data_out) !== e.sum) begin failures++; $display("FAIL t5_sum got %h want %h", adder(bus.data_out), e.sum); end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock); #1;
      checks++; if (bus.sum_valid !== 1'b1 || bus.data_out !== e.w) begin
        failures++; $display("FAIL t5_hold cyc %0d got sv=%b d=%h want 1/%h", c, bus.sum_valid, bus.data_out, e.w);
      end
    end
    bus.sum_ack = 1'b1;
    @(negedge clock); #1;
    checks++; if (bus.sum_valid !== 1'b0) begin failures++; $display("FAIL t5_ack_drop got sv=%b want 0", bus.sum_valid); end
    bus.sum_ack = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_frame_wrap();
    logic [1:0] want;
    bus2.sum_ack  = 1'b1;
    bus2.data_in  = 12'h007;
    bus2.in_valid = 1'b1;
    for (int f = 1; f <= 4; f++) begin
      for (int w = 0; w < NW; w++) begin
        #1;
        checks++; if (bus2.in_ready !== 1'b1) begin failures++; $display("FAIL t6_ready f%0d w%0d got %b want 1", f, w, bus2.in_ready); end
        @(negedge clock);
      end
      #1;
      want = 2'(f % 4);
      checks++; if (bus2.frame_cnt !== want) begin failures++; $display("FAIL t6_wrap f%0d got %0d want %0d", f, bus2.frame_cnt, want); end
    end
    bus2.in_valid = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gappy();
    test_reset_mid_frame();
    test_ack_ignored();
    test_frame_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
